// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared state encoding and mode constants for the pulse generator.
package pulse_gen_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/phase_counter.sv
// phase_counter: counts 0..limit-1 and flags the last phase so the caller can count periods.
module phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] phase,
    output logic             wrap
);

    logic [CNT_W-1:0] phase_q, phase_d;

    // limit is never zero, so limit-1 cannot underflow
    assign wrap  = (phase_q == limit - CNT_W'(1));
    assign phase = phase_q;

    always_comb begin
        phase_d = clear  ? '0 :
                  enable ? (wrap ? '0 : phase_q + CNT_W'(1)) :
                  phase_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase_q <= '0;
        else      phase_q <= phase_d;
    end

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable continuous or burst pulse train with registered out/busy/done.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 4,
    parameter int unsigned DEF_HIGH   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] burst_len,
    output logic             out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d, h_q, h_d, n_q, n_d, cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] p_in, h_in, n_in, phase, ph_nxt;
    logic             wrap, clr, en, finish;

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .enable (en),
        .limit  (p_q),
        .phase  (phase),
        .wrap   (wrap)
    );

    assign p_in   = (period == '0) ? CNT_W'(1) : period;
    assign h_in   = (high_len > p_in) ? p_in : high_len;
    assign n_in   = (burst_len == '0) ? CNT_W'(1) : burst_len;
    assign ph_nxt = wrap ? '0 : phase + CNT_W'(1);
    // burst ends on the wrap that completes the Nth period
    assign finish = (mode_q == MODE_BURST) && wrap && (cnt_q == n_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        h_d     = h_q;
        n_d     = n_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        if (start) begin
            state_d = RUN;
            p_d     = p_in;
            h_d     = h_in;
            n_d     = n_in;
            mode_d  = mode;
            cnt_d   = '0;
            out_d   = (h_in != '0);
            busy_d  = 1'b1;
            clr     = 1'b1;
        end else if (state_q == RUN) begin
            if (stop || finish) begin
                state_d = IDLE;
                cnt_d   = '0;
                out_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                clr     = 1'b1;
            end else begin
                en    = 1'b1;
                out_d = (ph_nxt < h_q);
                cnt_d = (wrap && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= CNT_W'(DEF_PERIOD);
            h_q     <= CNT_W'(DEF_HIGH);
            n_q     <= CNT_W'(1);
            mode_q  <= MODE_CONT;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            h_q     <= h_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
